// File: rtl/booth2_mul_pp_accumulator_pkg.sv
// Shared types and width helpers for the Booth radix-4 partial-product accumulator.
// Optional two-rows-per-cycle build is selected by BOOTH2_MUL_ACC_TWO_ROW_EN.
package booth2_mul_pp_accumulator_pkg;

  localparam int DEF_MUL_IN_WD = 32;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_DONE = 2'd2
  } acc_state_t;

  function automatic int pp_num(input int mul_in_wd);
    return mul_in_wd / 2;
  endfunction

  function automatic int pp_wd(input int mul_in_wd);
    return mul_in_wd + 1;
  endfunction

  function automatic int prd_wd(input int mul_in_wd);
    return 2 * mul_in_wd;
  endfunction

  // Row counter width; kept at least one bit so tiny operand widths still elaborate.
  function automatic int cnt_wd(input int mul_in_wd);
    return (mul_in_wd / 2 > 2) ? $clog2(mul_in_wd / 2) : 1;
  endfunction

endpackage

// File: rtl/booth2_mul_pp_accumulator_row_extend.sv
// booth2_mul_row_extend: sign-extends one Booth row, applies its negation
// correction bit and aligns it to weight 4^k in the product.
module booth2_mul_row_extend
  import booth2_mul_pp_accumulator_pkg::*;
#(
  parameter int MUL_IN_WD = DEF_MUL_IN_WD,
  localparam int PP_WD  = pp_wd(MUL_IN_WD),
  localparam int PRD_WD = prd_wd(MUL_IN_WD),
  localparam int CNT_WD = cnt_wd(MUL_IN_WD)
) (
  input  logic [PP_WD-1:0]  pp,
  input  logic              s,
  input  logic              e,
  input  logic [CNT_WD-1:0] k,
  output logic [PRD_WD-1:0] row
);

  logic [PRD_WD-1:0] ext;

  assign ext = {{(PRD_WD - PP_WD){e}}, pp} + PRD_WD'(s);
  assign row = ext << {k, 1'b0};

endmodule

// File: rtl/booth2_mul_pp_accumulator.sv
// Iterative accumulator of one Booth radix-4 partial-product set into a signed product.
// Define BOOTH2_MUL_ACC_TWO_ROW_EN to add two rows per cycle (halves the latency).
//
// state   | meaning
// IDLE    | rdy_o high, waiting for a partial-product set
// ACC     | adding captured rows into acc, cnt selects the row(s)
// DONE    | product presented on po with val_o, waiting for rdy_i
module booth2_mul_pp_accumulator
  import booth2_mul_pp_accumulator_pkg::*;
#(
  parameter int MUL_IN_WD = DEF_MUL_IN_WD,
  localparam int PP_NUM = pp_num(MUL_IN_WD),
  localparam int PP_WD  = pp_wd(MUL_IN_WD),
  localparam int PRD_WD = prd_wd(MUL_IN_WD)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    val_i,
  output logic                    rdy_o,
  input  logic [PP_NUM*PP_WD-1:0] ppi,
  input  logic [PP_NUM-1:0]       si,
  input  logic [PP_NUM-1:0]       ei,
  output logic                    val_o,
  input  logic                    rdy_i,
  output logic [PRD_WD-1:0]       po,
  output logic                    ovf_o
);

  localparam int CNT_WD = cnt_wd(MUL_IN_WD);
`ifdef BOOTH2_MUL_ACC_TWO_ROW_EN
  localparam logic [CNT_WD-1:0] CNT_STEP = CNT_WD'(2);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(PP_NUM - 2);
`else
  localparam logic [CNT_WD-1:0] CNT_STEP = CNT_WD'(1);
  localparam logic [CNT_WD-1:0] CNT_LAST = CNT_WD'(PP_NUM - 1);
`endif

  acc_state_t                    state_q, state_d;
  logic [PP_NUM-1:0][PP_WD-1:0]  pp_q;
  logic [PP_NUM-1:0]             si_q, ei_q;
  logic [CNT_WD-1:0]             cnt_q;
  logic [PRD_WD-1:0]             acc_q, po_q, acc_nxt, row0;
  logic                          ovf_q, last;

  assign last = (cnt_q == CNT_LAST);

  booth2_mul_row_extend #(.MUL_IN_WD(MUL_IN_WD)) u_row0 (
    .pp  (pp_q[cnt_q]),
    .s   (si_q[cnt_q]),
    .e   (ei_q[cnt_q]),
    .k   (cnt_q),
    .row (row0)
  );

`ifdef BOOTH2_MUL_ACC_TWO_ROW_EN
  logic [CNT_WD-1:0] cnt_p1;
  logic [PRD_WD-1:0] row1;

  // cnt is always even here, so cnt+1 is the odd partner row.
  assign cnt_p1 = cnt_q + CNT_WD'(1);

  booth2_mul_row_extend #(.MUL_IN_WD(MUL_IN_WD)) u_row1 (
    .pp  (pp_q[cnt_p1]),
    .s   (si_q[cnt_p1]),
    .e   (ei_q[cnt_p1]),
    .k   (cnt_p1),
    .row (row1)
  );

  assign acc_nxt = acc_q + row0 + row1;
`else
  assign acc_nxt = acc_q + row0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (val_i) state_d = ST_ACC;
      ST_ACC:  if (last)  state_d = ST_DONE;
      ST_DONE: if (rdy_i) state_d = ST_IDLE;
      default:            state_d = ST_IDLE;
    endcase
  end

  // rdy_o is masked by rst so it reads low for the whole reset pulse.
  always_comb begin
    rdy_o = 1'b0;
    val_o = 1'b0;
    case (state_q)
      ST_IDLE: rdy_o = ~rst;
      ST_DONE: val_o = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pp_q  <= '0;
      si_q  <= '0;
      ei_q  <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      po_q  <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (val_i && !rdy_o) ovf_q <= 1'b1;
      if (state_q == ST_IDLE && val_i) begin
        pp_q  <= ppi;
        si_q  <= si;
        ei_q  <= ei;
        cnt_q <= '0;
        acc_q <= '0;
      end else if (state_q == ST_ACC) begin
        acc_q <= acc_nxt;
        cnt_q <= cnt_q + CNT_STEP;
        if (last) po_q <= acc_nxt;
      end
    end
  end

  assign po    = po_q;
  assign ovf_o = ovf_q;

endmodule

// File: tb/tb_booth2_mul_pp_accumulator.sv
// Bench for booth2_mul_pp_accumulator: Booth radix-4 rows built from operand pairs,
// expected products queued at accept and compared on each val_o & rdy_i handshake.
module tb_booth2_mul_pp_accumulator;

`ifdef BOOTH2_MUL_ACC_TWO_ROW_EN
  localparam int LAT = 8;
`else
  localparam int LAT = 16;
`endif

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           val_i = 1'b0;
  logic           rdy_i = 1'b0;
  logic [16*33-1:0] ppi = '0;
  logic [15:0]    si = '0;
  logic [15:0]    ei = '0;
  logic           rdy_o, val_o, ovf_o;
  logic [63:0]    po;

  int             checks = 0;
  int             errors = 0;
  logic [63:0]    exp_q[$];
  bit             rdy_rand = 1'b0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] p;
  } vec_t;
  vec_t vecs[9];

  booth2_mul_pp_accumulator #(.MUL_IN_WD(32)) dut (
    .clk   (clk),
    .rst   (rst),
    .val_i (val_i),
    .rdy_o (rdy_o),
    .ppi   (ppi),
    .si    (si),
    .ei    (ei),
    .val_o (val_o),
    .rdy_i (rdy_i),
    .po    (po),
    .ovf_o (ovf_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Booth radix-4 encoding of b against a, in the upstream generator's row format.
  task automatic build(input logic [31:0] a, input logic [31:0] b);
    logic [32:0]        bx;
    logic signed [63:0] v, t;
    int                 d;
    bx = {b, 1'b0};
    for (int k = 0; k < 16; k++) begin
      d = int'(bx[2*k]) + int'(bx[2*k+1]) - 2 * int'(bx[2*k+2]);
      v = 64'(signed'(longint'(d))) * 64'(signed'(longint'($signed(a))));
      t = v - ((d < 0) ? 64'sd1 : 64'sd0);
      ppi[k*33 +: 33] = t[32:0];
      ei[k] = t[33];
      si[k] = (d < 0);
    end
  endtask

  task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [63:0] p,
                      input bit measure);
    int n;
    n = 0;
    while (!rdy_o && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!rdy_o) chk("rdy_o_timeout", {63'd0, rdy_o}, 64'd1);
    build(a, b);
    val_i = 1'b1;
    @(posedge clk);
    exp_q.push_back(p);
    #1 val_i = 1'b0;
    if (measure) begin
      n = 0;
      while (!val_o && n < 40) begin
        @(posedge clk); #1; n++;
      end
      chk("latency", 64'(n), 64'(LAT));
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || val_o) && n < 3000) begin
      @(posedge clk); #1; n++;
    end
    chk("drain", 64'(exp_q.size()), 64'd0);
  endtask

  // Monitor: a handshake completes on the edge after a negedge that sees val_o & rdy_i.
  initial begin
    logic [63:0] e;
    forever begin
      @(negedge clk);
      if (val_o && rdy_i && !rst) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_val_o: got po %h with nothing expected", po);
        end else begin
          e = exp_q.pop_front();
          chk("po", po, e);
        end
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rdy_rand) rdy_i = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ra, rb;
    logic [63:0] rp;
    vecs[0] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F};
    vecs[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'h0000_0000_0000_0001};
    vecs[2] = '{32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000};
    vecs[3] = '{32'h0000_0007, 32'hFFFF_FFFD, 64'hFFFF_FFFF_FFFF_FFEB};
    vecs[4] = '{32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001};
    vecs[5] = '{32'h8000_0000, 32'h7FFF_FFFF, 64'hC000_0000_8000_0000};
    vecs[6] = '{32'h0000_0064, 32'hFFFF_FF9C, 64'hFFFF_FFFF_FFFF_D8F0};
    vecs[7] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000};
    vecs[8] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000};

    @(negedge clk);
    chk("reset_rdy_o", {63'd0, rdy_o}, 64'd0);
    chk("reset_val_o", {63'd0, val_o}, 64'd0);
    chk("reset_po",    po,             64'd0);
    chk("reset_ovf_o", {63'd0, ovf_o}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rdy_after_reset", {63'd0, rdy_o}, 64'd1);

    rdy_i = 1'b1;
    for (int i = 0; i < 9; i++) send(vecs[i].a, vecs[i].b, vecs[i].p, (i < 2));
    drain();

    // Backpressure: hold the product in DONE for 10 cycles.
    rdy_i = 1'b0;
    send(32'h0001_2345, 32'h0000_0010, 64'h0000_0000_0012_3450, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_val_o", {63'd0, val_o}, 64'd1);
      chk("bp_po",    po,             64'h0000_0000_0012_3450);
      chk("bp_rdy_o", {63'd0, rdy_o}, 64'd0);
    end
    @(posedge clk); #1 rdy_i = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_val_o", {63'd0, val_o}, 64'd0);
    chk("bp_release_rdy_o", {63'd0, rdy_o}, 64'd1);

    // Overflow: a set offered during ACC is dropped.
    send(32'hFFFF_FFFE, 32'h0000_0003, 64'hFFFF_FFFF_FFFF_FFFA, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    chk("ovf_before", {63'd0, ovf_o}, 64'd0);
    build(32'h0000_0009, 32'h0000_0009);
    val_i = 1'b1;
    @(posedge clk); #1 val_i = 1'b0;
    chk("ovf_set", {63'd0, ovf_o}, 64'd1);
    drain();
    repeat (20) begin @(posedge clk); #1; end
    chk("ovf_no_extra_val_o", {63'd0, val_o}, 64'd0);
    chk("ovf_sticky", {63'd0, ovf_o}, 64'd1);

    // Reset five cycles into ACC aborts the set.
    send(32'h0000_1111, 32'h0000_2222, 64'h0000_0000_0246_8642, 1'b0);
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_val_o", {63'd0, val_o}, 64'd0);
    chk("midrst_po",    po,             64'd0);
    chk("midrst_rdy_o", {63'd0, rdy_o}, 64'd0);
    chk("midrst_ovf_o", {63'd0, ovf_o}, 64'd0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    send(32'h0000_0002, 32'h0000_0002, 64'h0000_0000_0000_0004, 1'b1);
    drain();

    // Random signed operands with random downstream ready.
    rdy_rand = 1'b1;
    for (int i = 0; i < 150; i++) begin
      ra = $urandom;
      rb = $urandom;
      rp = 64'(longint'($signed(ra)) * longint'($signed(rb)));
      send(ra, rb, rp, 1'b0);
    end
    drain();
    rdy_rand = 1'b0;
    rdy_i = 1'b1;
    repeat (3) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
